control_conditioner: RTL and testbench

Input conditioning stage directly upstream of the Mealy sequence detector: takes a raw, asynchronous, possibly bouncing control input and produces the clean, debounced `control` level the detector samples. Also emits single-cycle rise/fall strobes and a saturating count of rejected glitches for debug. Fully synchronous to `clk` apart from the asynchronous reset.

---
 rtl/control_conditioner.sv | 143 ++++++++++++++
 tb/tb_control_conditioner.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/control_conditioner.sv
// Debounces an asynchronous control input, emits rise/fall strobes and counts rejected glitches.
// Latency: 2+DEBOUNCE_CYCLES edges from capture with CONTROL_COND_SYNC_EN, 1+DEBOUNCE_CYCLES without.
// Backpressure: none; free-running sampler, all outputs registered.
module control_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       raw_in,
    output logic       control,
    output logic       rise_pulse,
    output logic       fall_pulse,
    output logic [7:0] glitch_cnt
);

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        WAIT_HI   = 2'd1,
        STABLE_HI = 2'd2,
        WAIT_LO   = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] DB_MAX  = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic s;

`ifdef CONTROL_COND_SYNC_EN
    // Two-flop synchroniser for a truly asynchronous source.
    logic [1:0] sync_q;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) sync_q <= 2'b00;
        else        sync_q <= {sync_q[0], raw_in};
    end
    assign s = sync_q[1];
`else
    // Single sampling flop; the source is already synchronous to clk.
    logic sync_q;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) sync_q <= 1'b0;
        else        sync_q <= raw_in;
    end
    assign s = sync_q;
`endif

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             control_q, control_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic [7:0]       glitch_q, glitch_d;
    logic [7:0]       glitch_inc;

    // Saturating glitch counter increment, used whenever a candidate edge is aborted.
    assign glitch_inc = (glitch_q == 8'hFF) ? glitch_q : glitch_q + 8'd1;

    // Next-state and registered-output decode for the debounce FSM.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        control_d = control_q;
        rise_d    = 1'b0;
        fall_d    = 1'b0;
        glitch_d  = glitch_q;
        case (state_q)
            STABLE_LO: begin
                if (s) begin
                    state_d = WAIT_HI;
                    cnt_d   = CNT_ONE;
                end
            end
            WAIT_HI: begin
                if (s) begin
                    if (cnt_q >= DB_MAX) begin
                        state_d   = STABLE_HI;
                        control_d = 1'b1;
                        rise_d    = 1'b1;
                        cnt_d     = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end else begin
                    state_d  = STABLE_LO;
                    cnt_d    = '0;
                    glitch_d = glitch_inc;
                end
            end
            STABLE_HI: begin
                if (!s) begin
                    state_d = WAIT_LO;
                    cnt_d   = CNT_ONE;
                end
            end
            WAIT_LO: begin
                if (!s) begin
                    if (cnt_q >= DB_MAX) begin
                        state_d   = STABLE_LO;
                        control_d = 1'b0;
                        fall_d    = 1'b1;
                        cnt_d     = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end else begin
                    state_d  = STABLE_HI;
                    cnt_d    = '0;
                    glitch_d = glitch_inc;
                end
            end
            default: begin
                state_d   = STABLE_LO;
                cnt_d     = '0;
                control_d = 1'b0;
            end
        endcase
    end

    // State, counter and output registers; reset aborts any pending transition.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= STABLE_LO;
            cnt_q     <= '0;
            control_q <= 1'b0;
            rise_q    <= 1'b0;
            fall_q    <= 1'b0;
            glitch_q  <= 8'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            control_q <= control_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            glitch_q  <= glitch_d;
        end
    end

    assign control    = control_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
    assign glitch_cnt = glitch_q;

endmodule

// File: tb/tb_control_conditioner.sv
// Directed bench for control_conditioner: reset, clean edges, glitches, reset mid-wait, saturation.
// Latency: expectations track the sync depth selected by CONTROL_COND_SYNC_EN.
// Backpressure: not applicable; stimulus driven 1 ns after each rising edge.
module tb_control_conditioner;

    localparam int N = 4;
`ifdef CONTROL_COND_SYNC_EN
    localparam int SYNC = 2;
`else
    localparam int SYNC = 1;
`endif
    // Index of the edge (capture edge = 0) at which control commits.
    localparam int LAT = SYNC + N;

    logic       clk = 1'b0;
    logic       reset;
    logic       raw_in;
    logic       control;
    logic       rise_pulse;
    logic       fall_pulse;
    logic [7:0] glitch_cnt;

    int n_checks = 0;
    int n_err    = 0;

    control_conditioner #(
        .DEBOUNCE_CYCLES(N),
        .CNT_W(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .raw_in(raw_in),
        .control(control),
        .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse),
        .glitch_cnt(glitch_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag, input logic ctl, input logic [7:0] gl);
        chk({tag, "_ctl"}, 32'(control), 32'(ctl));
        chk({tag, "_rise"}, 32'(rise_pulse), 32'd0);
        chk({tag, "_fall"}, 32'(fall_pulse), 32'd0);
        chk({tag, "_glitch"}, 32'(glitch_cnt), 32'(gl));
    endtask

    // Drive raw_in to lvl and check the committed edge lands exactly at edge LAT.
    task automatic edge_run(input string tag, input logic lvl);
        raw_in = lvl;
        for (int i = 0; i <= LAT; i++) begin
            tick();
            chk({tag, "_ctl"}, 32'(control), (i == LAT) ? 32'(lvl) : 32'(!lvl));
            chk({tag, "_rise"}, 32'(rise_pulse), 32'((i == LAT) && lvl));
            chk({tag, "_fall"}, 32'(fall_pulse), 32'((i == LAT) && !lvl));
        end
        tick();
        chk({tag, "_ctl_hold"}, 32'(control), 32'(lvl));
        chk({tag, "_rise_off"}, 32'(rise_pulse), 32'd0);
        chk({tag, "_fall_off"}, 32'(fall_pulse), 32'd0);
    endtask

    // One raw_in excursion of len cycles from low, followed by a settling gap.
    task automatic glitch(input int len);
        raw_in = 1'b1;
        repeat (len) tick();
        raw_in = 1'b0;
        repeat (SYNC + 3) tick();
    endtask

    initial begin
        // Reset held 100 ns with raw_in low.
        reset  = 1'b0;
        raw_in = 1'b0;
        #1;
        chk_quiet("reset_early", 1'b0, 8'd0);
        repeat (10) tick();
        chk_quiet("reset_late", 1'b0, 8'd0);
        reset = 1'b1;
        repeat (8) tick();
        chk_quiet("post_reset", 1'b0, 8'd0);

        // Clean rise, then clean fall.
        edge_run("rise", 1'b1);
        repeat (3) tick();
        chk_quiet("rise_settled", 1'b1, 8'd0);
        edge_run("fall", 1'b0);
        repeat (3) tick();
        chk_quiet("fall_settled", 1'b0, 8'd0);

        // Reset asserted while a rising candidate is pending.
        raw_in = 1'b1;
        repeat (SYNC + 2) tick();
        chk_quiet("midwait_pending", 1'b0, 8'd0);
        reset = 1'b0;
        #1;
        chk_quiet("midwait_reset", 1'b0, 8'd0);
        tick();
        tick();
        chk_quiet("midwait_hold", 1'b0, 8'd0);
        reset = 1'b1;
        edge_run("midwait_rise", 1'b1);
        chk("midwait_glitch", 32'(glitch_cnt), 32'd0);
        edge_run("midwait_fall", 1'b0);

        // Three-cycle excursion is rejected and counted once.
        raw_in = 1'b1;
        repeat (3) tick();
        raw_in = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk({"short_ctl"}, 32'(control), 32'd0);
            chk({"short_rise"}, 32'(rise_pulse), 32'd0);
        end
        chk("short_glitch", 32'(glitch_cnt), 32'd1);

        // Glitch on the high side is counted and does not drop control.
        edge_run("hi_rise", 1'b1);
        raw_in = 1'b0;
        repeat (2) tick();
        raw_in = 1'b1;
        repeat (SYNC + 3) tick();
        chk_quiet("hi_glitch", 1'b1, 8'd2);
        edge_run("hi_fall", 1'b0);

        // Saturation: 260 two-cycle glitches on top of the two already counted.
        repeat (252) glitch(2);
        chk_quiet("sat_254", 1'b0, 8'd254);
        glitch(2);
        chk_quiet("sat_255", 1'b0, 8'd255);
        repeat (7) glitch(2);
        chk_quiet("sat_hold", 1'b0, 8'd255);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
